// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide sequencer and the
// execute-stage ALU decoder.
//   - operand width and iteration count
//   - operation codes carried on the request channel
//   - ALU opcodes (shared with the ALU decoder)
//   - sequencer state encoding
//   - result selection helper
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // The upper register holds acc (multiply) or rem (divide); the lower one
  // holds mq (multiply) or quot (divide). MULHU and REMU both want the upper
  // register, MUL and DIVU the lower one, so op bit 0 alone selects.
  function automatic logic [WIDTH-1:0] pick_result(input op_e op,
                                                   input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo);
    return op[0] ? hi : lo;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Request/response handshake bundle between the execute stage and the
// multiply/divide sequencer.
//   in_valid/in_ready/in_op/in_a/in_b : operation request
//   out_valid/out_ready/out_data      : result return
// Modports:
//   master : execute stage side (issues requests, consumes results)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative unsigned multiply/divide controller that borrows the shared
// 32-bit ALU: 32 shift-add steps for MUL/MULHU, 32 restoring subtract steps
// for DIVU/REMU. One operation in flight at a time.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_kill            synchronous abort (pipeline flush), highest priority
//   bus               request/response handshake (slave side)
//   o_busy            high in RUN or DONE; execute stage stalls and hands
//                     the ALU over to this block
//   o_alu_a, o_alu_b  ALU operands
//   o_alu_op          ALU opcode (ALU_ADD / ALU_SUB)
//   i_alu_result      ALU result, consumed in the same cycle
//   i_alu_u_slt       ALU unsigned less-than flag (valid for ALU_SUB)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request, in_ready high, ALU inputs zeroed
// ST_RUN  | one ALU step per cycle, r_cnt counts 0..ITERS-1
// ST_DONE | result held on out_data with out_valid until out_ready
// ---------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_kill,
  muldiv_sequencer_if.slave bus,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_u_slt
);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_acc;     // acc for multiply, rem for divide
  logic [WIDTH-1:0] r_mq;      // mq for multiply, quot for divide
  logic [WIDTH-1:0] r_mcand;   // mcand for multiply, dvs for divide
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_div;
  logic             w_last;
  logic [WIDTH-1:0] w_step_a;
  logic [WIDTH-1:0] w_step_b;
  logic             w_carry;
  logic             w_ok;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mq_nxt;

  assign w_is_div = r_op[1];
  assign w_last   = (r_cnt == CNT_W'(ITERS - 1));

  assign bus.out_data = r_out_data;

  // Operands for the current step; only forwarded to the ALU while in RUN.
  always_comb begin
    if (w_is_div) begin
      w_step_a = {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
      w_step_b = r_mcand;
    end else begin
      w_step_a = r_acc;
      w_step_b = r_mq[0] ? r_mcand : '0;
    end
  end

  // Next datapath values from the ALU result.
  always_comb begin
    // Add overflowed iff the sum wrapped below its first operand.
    w_carry = (i_alu_result < w_step_a);
    // A set rem MSB means the shifted partial remainder is >= 2^32, which
    // always exceeds the divisor even though the 32-bit compare says otherwise.
    w_ok    = r_acc[WIDTH-1] | ~i_alu_u_slt;
    if (w_is_div) begin
      w_acc_nxt = w_ok ? i_alu_result : w_step_a;
      w_mq_nxt  = {r_mq[WIDTH-2:0], w_ok};
    end else begin
      w_acc_nxt = {w_carry, i_alu_result[WIDTH-1:1]};
      w_mq_nxt  = {i_alu_result[0], r_mq[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    o_busy        = 1'b0;
    o_alu_a       = '0;
    o_alu_b       = '0;
    o_alu_op      = ALU_ADD;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_busy   = 1'b1;
        o_alu_a  = w_step_a;
        o_alu_b  = w_step_b;
        o_alu_op = w_is_div ? ALU_SUB : ALU_ADD;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_busy        = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_kill) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op       <= OP_MUL;
      r_acc      <= '0;
      r_mq       <= '0;
      r_mcand    <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else if (i_kill) begin
      // Partial results are simply abandoned; out_data keeps its last value.
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op  <= op_e'(bus.in_op);
            r_acc <= '0;
            r_cnt <= '0;
            if (bus.in_op[1]) begin
              r_mq    <= bus.in_a;
              r_mcand <= bus.in_b;
            end else begin
              r_mq    <= bus.in_b;
              r_mcand <= bus.in_a;
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_mq  <= w_mq_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_out_data <= pick_result(r_op, w_acc_nxt, w_mq_nxt);
        end
        default: ;
      endcase
    end
  end

endmodule
